alu_mult_seq: RTL
=================

Name: alu_mult_seq

Overview:
- Multi-cycle 32x32 -> 64-bit multiply sequencer that time-shares the existing combinational ALU.
- Drives ALU opcode and operands for every add, subtract and XOR step. Does shifts, carry recovery and sequencing itself.
- Sits beside the execute-stage ALU. The execute mux hands the ALU to this block while alu_req=1.
- Serves MULT/MULTU. Results land in prod_hi/prod_lo (HI/LO).

Parameters:
- WIDTH, 32, operand width. The product is 2*WIDTH. Only 32 is supported; other values are illegal.

Ports:
- CLK  in  1  clock, rising edge
- nRST  in  1  asynchronous active-low reset
- start  in  1  request pulse; sampled only in IDLE
- signed_op  in  1  1 = signed (MULT), 0 = unsigned (MULTU); sampled with start
- a  in  32  multiplicand; sampled with start
- b  in  32  multiplier; sampled with start
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse in DONE
- prod_hi  out  32  product [63:32]
- prod_lo  out  32  product [31:0]
- alu_req  out  1  ALU ownership request; high in every state except IDLE and DONE
- alu_opcode  out  aluop_t (4)  opcode to the ALU
- alu_op1  out  32  ALU operand 1
- alu_op2  out  32  ALU operand 2
- alu_result  in  32  ALU result, same cycle (combinational)

Behaviour:
- Reset (async, nRST=0):
  - state=IDLE; busy=done=alu_req=0; prod_hi=prod_lo=0; counter=0.
  - All internal registers clear. Reset mid-operation aborts immediately; there is no partial result.
- ALU drive outside active states: opcode=ALU_ADD, op1=op2=0.
- State sequence: IDLE, NEG_A, NEG_B, MUL, NEG_LO, NOT_HI, INC_HI, DONE.
- IDLE:
  - On start=1, latch a into mcand and b into lo. Clear hi. Set counter=0.
  - Latch sgn = signed_op & (a[31]^b[31]).
  - Next state is NEG_A if signed_op=1, else MUL.
- NEG_A: ALU_SUB, op1=0, op2=mcand. Write mcand=alu_result if mcand[31]=1, else leave it. Next state NEG_B.
- NEG_B: ALU_SUB, op1=0, op2=lo. Write lo=alu_result if lo[31]=1, else leave it. Next state MUL.
  - The magnitude of 0x80000000 is 0x80000000, treated as unsigned.
- MUL, one iteration per cycle:
  - ALU_ADD, op1=hi, op2 = lo[0] ? mcand : 0.
  - Carry c = (op1[31]&op2[31]) | ((op1[31]|op2[31]) & ~alu_result[31]).
  - Update hi <= {c, alu_result[31:1]}, lo <= {alu_result[0], lo[31:1]}.
  - Increment the counter.
  - After the 32nd iteration (counter==31 this cycle): next state is NEG_LO if sgn, else DONE.
- NEG_LO: ALU_SUB, op1=0, op2=lo. lo <= alu_result. Record lz = (lo==0), using the pre-negation value.
- NOT_HI: ALU_XOR, op1=hi, op2=32'hFFFFFFFF. hi <= alu_result.
- INC_HI: ALU_ADD, op1=hi, op2={31'b0, lz}. hi <= alu_result. Next state DONE.
- DONE:
  - prod_hi <= hi, prod_lo <= lo. The outputs change on the edge entering DONE, so they are valid while done=1.
  - done=1 for exactly one cycle. Next state IDLE.
- Start handling:
  - start is ignored while busy, including in DONE; it is not queued.
  - start in the first IDLE cycle after DONE is accepted.
- Latency, from the start edge to the done cycle:
  - unsigned: 33 cycles
  - signed, same signs: 35 cycles
  - signed, different signs: 38 cycles
- prod_hi/prod_lo hold their last value until the next DONE.
- The ALU overflow flag (vf) and the nf/zf flags are ignored.

Optional Feature:
- Macro: MULT_EARLY_EXIT_EN.
- When defined: in MUL, if the remaining unconsumed multiplier bits are all zero, finish the remaining shifts in that single cycle and leave MUL.
  - Remaining bits are lo[31-counter:0] before the update.
  - The finishing shift places the partial product correctly: {hi,lo} >> remaining count.
  - Latency shrinks accordingly. Example: unsigned b=1 reaches DONE 3 cycles after start.
  - Results are bit-identical to the feature-off build.
- When undefined: always exactly 32 MUL cycles.

Test Plan:
- Unsigned: start, signed_op=0, a=0x0000FFFF, b=0x00010001 -> done at cycle 33, prod_hi=0x00000000, prod_lo=0xFFFFFFFF.
- Unsigned max: a=b=0xFFFFFFFF -> prod_hi=0xFFFFFFFE, prod_lo=0x00000001. Carry recovery exercised every iteration.
- Signed mixed: a=0xFFFFFFFD (-3), b=7 -> done at cycle 38, {prod_hi,prod_lo}=0xFFFFFFFF_FFFFFFEB. Also a=0x80000000, b=0x80000000 -> 0x40000000_00000000, done at cycle 35.
- Signed zero, different signs: a=0x80000000, b=0 -> prod=0. Exercises lz=1 in INC_HI.
- Handshake:
  - start held high through a whole operation -> exactly one done per accepted start.
  - A second start asserted in DONE is ignored; a start in the next IDLE cycle is accepted.
  - alu_req is low in IDLE and DONE.
- Reset: nRST=0 at MUL iteration 10 -> busy, done and alu_req drop asynchronously; prod_hi/prod_lo are 0. A following unsigned 6x7 returns 42 at cycle 33.

Source files
------------

// File: rtl/alu_mult_seq.sv
// alu_mult_seq: 32x32 -> 64-bit shift-add multiplier that borrows the execute ALU for every add/sub/xor step.
// Build option MULT_EARLY_EXIT_EN: leave MUL as soon as the unconsumed multiplier bits are all zero.
package alu_mult_seq_pkg;
    typedef enum logic [3:0] {
        ALU_ADD = 4'h0,
        ALU_SUB = 4'h1,
        ALU_AND = 4'h2,
        ALU_OR  = 4'h3,
        ALU_XOR = 4'h4
    } aluop_t;
endpackage

module alu_mult_seq
    import alu_mult_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] prod_hi,
    output logic [WIDTH-1:0] prod_lo,
    output logic             alu_req,
    output aluop_t           alu_opcode,
    output logic [WIDTH-1:0] alu_op1,
    output logic [WIDTH-1:0] alu_op2,
    input  logic [WIDTH-1:0] alu_result
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_NEG_A  = 3'd1;
    localparam logic [2:0] S_NEG_B  = 3'd2;
    localparam logic [2:0] S_MUL    = 3'd3;
    localparam logic [2:0] S_NEG_LO = 3'd4;
    localparam logic [2:0] S_NOT_HI = 3'd5;
    localparam logic [2:0] S_INC_HI = 3'd6;
    localparam logic [2:0] S_DONE   = 3'd7;

    logic [2:0]       state_q, state_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [4:0]       cnt_q, cnt_d;
    logic             sgn_q, sgn_d;
    logic             lz_q, lz_d;
    logic [WIDTH-1:0] prod_hi_q, prod_hi_d;
    logic [WIDTH-1:0] prod_lo_q, prod_lo_d;
    logic             carry;
    logic             mul_last;
`ifdef MULT_EARLY_EXIT_EN
    logic             rem_zero;
    logic [5:0]       rem_cnt;
    logic [2*WIDTH-1:0] shifted;
`endif

    always_comb begin
        state_d    = state_q;
        mcand_d    = mcand_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        cnt_d      = cnt_q;
        sgn_d      = sgn_q;
        lz_d       = lz_q;
        prod_hi_d  = prod_hi_q;
        prod_lo_d  = prod_lo_q;
        alu_opcode = ALU_ADD;
        alu_op1    = '0;
        alu_op2    = '0;
        carry      = 1'b0;
        mul_last   = 1'b0;
`ifdef MULT_EARLY_EXIT_EN
        rem_zero   = 1'b0;
        rem_cnt    = '0;
        shifted    = '0;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mcand_d = a;
                    lo_d    = b;
                    hi_d    = '0;
                    cnt_d   = '0;
                    sgn_d   = signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
                    state_d = signed_op ? S_NEG_A : S_MUL;
                end
            end
            S_NEG_A: begin
                alu_opcode = ALU_SUB;
                alu_op2    = mcand_q;
                if (mcand_q[WIDTH-1]) mcand_d = alu_result;
                state_d    = S_NEG_B;
            end
            S_NEG_B: begin
                alu_opcode = ALU_SUB;
                alu_op2    = lo_q;
                if (lo_q[WIDTH-1]) lo_d = alu_result;
                state_d    = S_MUL;
            end
            S_MUL: begin
                alu_op1  = hi_q;
                alu_op2  = lo_q[0] ? mcand_q : '0;
                // ALU gives only 32 bits; rebuild the carry-out from the operand and sum MSBs
                carry    = (alu_op1[WIDTH-1] & alu_op2[WIDTH-1]) |
                           ((alu_op1[WIDTH-1] | alu_op2[WIDTH-1]) & ~alu_result[WIDTH-1]);
                hi_d     = {carry, alu_result[WIDTH-1:1]};
                lo_d     = {alu_result[0], lo_q[WIDTH-1:1]};
                cnt_d    = cnt_q + 5'd1;
                mul_last = (cnt_q == 5'd31);
`ifdef MULT_EARLY_EXIT_EN
                rem_zero = (lo_q & ({WIDTH{1'b1}} >> cnt_q)) == '0;
                if (rem_zero) begin
                    rem_cnt  = 6'd32 - {1'b0, cnt_q};
                    shifted  = {hi_q, lo_q} >> rem_cnt;
                    hi_d     = shifted[2*WIDTH-1:WIDTH];
                    lo_d     = shifted[WIDTH-1:0];
                    mul_last = 1'b1;
                end
`endif
                if (mul_last) state_d = sgn_q ? S_NEG_LO : S_DONE;
            end
            S_NEG_LO: begin
                alu_opcode = ALU_SUB;
                alu_op2    = lo_q;
                lo_d       = alu_result;
                lz_d       = (lo_q == '0);
                state_d    = S_NOT_HI;
            end
            S_NOT_HI: begin
                alu_opcode = ALU_XOR;
                alu_op1    = hi_q;
                alu_op2    = '1;
                hi_d       = alu_result;
                state_d    = S_INC_HI;
            end
            S_INC_HI: begin
                alu_op1 = hi_q;
                alu_op2 = {{(WIDTH-1){1'b0}}, lz_q};
                hi_d    = alu_result;
                state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
        // load the product on the edge into DONE so it is already valid while done=1
        if (state_d == S_DONE && state_q != S_DONE) begin
            prod_hi_d = hi_d;
            prod_lo_d = lo_d;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q   <= S_IDLE;
            mcand_q   <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            cnt_q     <= '0;
            sgn_q     <= 1'b0;
            lz_q      <= 1'b0;
            prod_hi_q <= '0;
            prod_lo_q <= '0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            cnt_q     <= cnt_d;
            sgn_q     <= sgn_d;
            lz_q      <= lz_d;
            prod_hi_q <= prod_hi_d;
            prod_lo_q <= prod_lo_d;
        end
    end

    assign busy    = (state_q != S_IDLE);
    assign done    = (state_q == S_DONE);
    assign alu_req = busy & ~done;
    assign prod_hi = prod_hi_q;
    assign prod_lo = prod_lo_q;

endmodule
